// File: rtl/counter_mod_pkg.sv
// counter_mod_pkg
//   Shared encodings for the bounded up/down counter.
//   MODE_WRAP / MODE_SAT : values of sat_mode
//   DIR_DOWN  / DIR_UP   : values of upndwn
package counter_mod_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/counter_mod_step.sv
// counter_mod_step
//   Combinational next-count arithmetic for counter_mod.
//   Ports:
//     cnt      in  WIDTH   current count
//     max_val  in  WIDTH   upper bound of the legal range 0..max_val
//     step     in  STEP_W  requested step magnitude
//     upndwn   in  1       DIR_UP / DIR_DOWN
//     sat_mode in  1       MODE_SAT / MODE_WRAP
//     next_cnt out WIDTH   count after one enabled step
//     bnd_evt  out 1       the step crossed (or started outside) a bound
module counter_mod_step
  import counter_mod_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  cnt,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [STEP_W-1:0] step,
  input  logic              upndwn,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  next_cnt,
  output logic              bnd_evt
);

  logic [WIDTH-1:0] step_ext;
  logic [WIDTH-1:0] eff_step;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   range_len;

  always_comb begin
    step_ext  = WIDTH'(step);
    // A step larger than the whole range is clamped to max_val.
    eff_step  = (step_ext < max_val) ? step_ext : max_val;
    sum       = {1'b0, cnt} + {1'b0, eff_step};
    range_len = {1'b0, max_val} + {{WIDTH{1'b0}}, 1'b1};
    next_cnt  = cnt;
    bnd_evt   = 1'b0;

    if (eff_step == '0) begin
      // Zero effective step: hold, never an event.
      next_cnt = cnt;
    end else if (cnt > max_val) begin
      // Count left stranded above a lowered bound.
      bnd_evt  = 1'b1;
      next_cnt = (sat_mode == MODE_SAT) ? max_val : '0;
    end else if (upndwn == DIR_UP) begin
      if (sum > {1'b0, max_val}) begin
        bnd_evt  = 1'b1;
        next_cnt = (sat_mode == MODE_SAT) ? max_val : WIDTH'(sum - range_len);
      end else begin
        next_cnt = sum[WIDTH-1:0];
      end
    end else begin
      if (eff_step > cnt) begin
        bnd_evt  = 1'b1;
        next_cnt = (sat_mode == MODE_SAT) ? '0
                 : WIDTH'({1'b0, cnt} + range_len - {1'b0, eff_step});
      end else begin
        next_cnt = cnt - eff_step;
      end
    end
  end

endmodule

// File: rtl/counter_mod.sv
// counter_mod
//   Bounded up/down counter with load, variable step, wrap/saturate modes,
//   a terminal-count pulse and a sticky boundary flag.
//   Ports:
//     clk       in  1       clock, rising edge
//     reset     in  1       asynchronous active-low reset
//     enable    in  1       count one step
//     upndwn    in  1       1 = up, 0 = down
//     load      in  1       load min(load_val, max_val); beats enable
//     load_val  in  WIDTH   value to load
//     max_val   in  WIDTH   upper bound
//     step      in  STEP_W  step magnitude
//     sat_mode  in  1       1 = saturate, 0 = wrap
//     clr_ovf   in  1       clear sticky ovf (a same-cycle event wins)
//     cnt       out WIDTH   registered count
//     tc        out 1       registered boundary-event pulse
//     ovf       out 1       registered sticky boundary flag
module counter_mod
  import counter_mod_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              upndwn,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  cnt,
  output logic              tc,
  output logic              ovf
);

  logic [WIDTH-1:0] cnt_reg;
  logic             tc_reg;
  logic             ovf_reg;
  logic [WIDTH-1:0] step_next;
  logic             step_evt;
  logic [WIDTH-1:0] load_clamped;
  logic             evt_next;

  counter_mod_step #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .cnt      (cnt_reg),
    .max_val  (max_val),
    .step     (step),
    .upndwn   (upndwn),
    .sat_mode (sat_mode),
    .next_cnt (step_next),
    .bnd_evt  (step_evt)
  );

  assign load_clamped = (load_val < max_val) ? load_val : max_val;
  // Only an enabled count that is not overridden by load can be an event.
  assign evt_next     = enable & ~load & step_evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      if (load) begin
        cnt_reg <= load_clamped;
        tc_reg  <= 1'b0;
      end else if (enable) begin
        cnt_reg <= step_next;
        tc_reg  <= step_evt;
      end else begin
        tc_reg  <= 1'b0;
      end

      if (evt_next) begin
        ovf_reg <= 1'b1;
      end else if (clr_ovf) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign cnt = cnt_reg;
  assign tc  = tc_reg;
  assign ovf = ovf_reg;

endmodule
